// File: rtl/auth_seq_blk.sv
// rtl/auth_seq_blk.sv - BLE UART multi-byte GO-code power authorisation with timeout and lockout
// 8N1 receiver feeding an OFF/COLLECT/ON/STOP_PEND/LOCKED authorisation FSM.

module auth_seq_blk #(
    parameter int                    BAUD_DIV    = 5208,
    parameter int                    CODE_LEN    = 2,
    parameter logic [CODE_LEN*8-1:0] GO_CODE     = 16'h4731,
    parameter logic [7:0]            STOP_CODE   = 8'h53,
    parameter int                    SEQ_TIMEOUT = 2_500_000,
    parameter int                    MAX_FAIL    = 3,
    parameter int                    LOCK_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic RX,
    input  logic rider_off,
    output logic pwr_up,
    output logic locked,
    output logic frm_err
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int IW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(SEQ_TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    localparam logic [BW-1:0] C_HALF = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] C_FULL = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_OFF, S_COLLECT, S_ON, S_STOP_PEND, S_LOCKED} auth_state_t;

    rx_state_t   r_rx_state, w_rx_next;
    auth_state_t r_state, w_next;

    logic          r_rx_s1, r_rx_s2, r_rx_s3;
    logic [BW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_byte_vld;
    logic          r_frm_err;

    logic [IW-1:0] r_idx;
    logic [FW-1:0] r_fails;
    logic [TW-1:0] r_seq_tmr;
    logic [LW-1:0] r_lock_tmr;

    logic          w_fall, w_half_tick, w_bit_tick;
    logic [7:0]    w_go_idx;
    logic          w_is_go0, w_is_stop, w_is_match, w_last;
    logic          w_timeout, w_fail, w_lock_now, w_lock_done;
    logic [FW-1:0] w_fails_inc;

    // Third flop gives a true falling edge, so a line still low after a bad stop bit does not restart.
    assign w_fall      = r_rx_s3 & ~r_rx_s2;
    assign w_half_tick = (r_baud_cnt == C_HALF);
    assign w_bit_tick  = (r_baud_cnt == C_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        unique case (r_rx_state)
            RX_IDLE:  if (w_fall) w_rx_next = RX_START;
            RX_START: if (w_half_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bit_tick && r_bit_idx == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_bit_tick) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_byte_vld <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_rx_s1    <= RX;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_byte_vld <= 1'b0;
            r_frm_err  <= 1'b0;
            if (r_rx_state == RX_IDLE || w_rx_next != r_rx_state ||
                (r_rx_state != RX_START && w_bit_tick)) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
            if (r_rx_state == RX_IDLE) begin
                r_bit_idx <= '0;
            end
            if (r_rx_state == RX_DATA && w_bit_tick) begin
                r_shift   <= {r_rx_s2, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (r_rx_state == RX_STOP && w_bit_tick) begin
                r_byte_vld <= r_rx_s2;
                r_frm_err  <= ~r_rx_s2;
            end
        end
    end

    // GO bytes are stored most significant first.
    always_comb begin
        w_go_idx = GO_CODE[CODE_LEN*8-1 -: 8];
        for (int g = 0; g < CODE_LEN; g++) begin
            if (r_idx == IW'(g)) w_go_idx = GO_CODE[8*(CODE_LEN-1-g) +: 8];
        end
    end

    assign w_is_go0    = r_byte_vld && (r_shift == GO_CODE[CODE_LEN*8-1 -: 8]);
    assign w_is_stop   = r_byte_vld && (r_shift == STOP_CODE);
    assign w_is_match  = r_byte_vld && (r_shift == w_go_idx);
    assign w_last      = (r_idx == IW'(CODE_LEN - 1));
    assign w_timeout   = (r_seq_tmr == TW'(SEQ_TIMEOUT)) && !r_byte_vld;
    assign w_fail      = (r_state == S_COLLECT) && ((r_byte_vld && !w_is_match) || w_timeout);
    assign w_fails_inc = r_fails + 1'b1;
    assign w_lock_now  = (w_fails_inc == FW'(MAX_FAIL));
    assign w_lock_done = (r_lock_tmr == LW'(LOCK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_OFF:       if (w_is_go0) w_next = (CODE_LEN == 1) ? S_ON : S_COLLECT;
            S_COLLECT: begin
                if (w_is_match && w_last) w_next = S_ON;
                else if (w_fail)          w_next = w_lock_now ? S_LOCKED : S_OFF;
            end
            S_ON:        if (w_is_stop) w_next = rider_off ? S_OFF : S_STOP_PEND;
            S_STOP_PEND: begin
                if (rider_off)     w_next = S_OFF;
                else if (w_is_go0) w_next = S_ON;
            end
            S_LOCKED:    if (w_lock_done) w_next = S_OFF;
            default:     w_next = S_OFF;
        endcase
    end

    always_comb begin
        pwr_up  = (r_state == S_ON) || (r_state == S_STOP_PEND);
        locked  = (r_state == S_LOCKED);
        frm_err = r_frm_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_fails    <= '0;
            r_seq_tmr  <= '0;
            r_lock_tmr <= '0;
        end else begin
            unique case (r_state)
                S_OFF: begin
                    if (w_is_go0 && CODE_LEN > 1) begin
                        r_idx     <= IW'(1);
                        r_seq_tmr <= '0;
                    end
                end
                S_COLLECT: begin
                    if (w_is_match) begin
                        r_seq_tmr <= '0;
                        if (w_last) begin
                            r_idx   <= '0;
                            r_fails <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else if (w_fail) begin
                        r_idx     <= '0;
                        r_seq_tmr <= '0;
                        r_fails   <= w_fails_inc;
                    end else if (r_seq_tmr != TW'(SEQ_TIMEOUT)) begin
                        r_seq_tmr <= r_seq_tmr + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (w_lock_done) begin
                        r_lock_tmr <= '0;
                        r_fails    <= '0;
                    end else begin
                        r_lock_tmr <= r_lock_tmr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/auth_seq_blk.md
# auth_seq_blk

Parametrised successor to the single-byte Segway authorisation block. It receives 8N1 serial bytes from the Bluetooth module on `RX`. It requires a multi-byte GO code to power up, and keeps the rider-aware stop-pending behaviour. It adds a sequence timeout and a lockout after repeated failed attempts. It sits between the BLE UART pin and the power-enable input of the balance controller.

## Interface
- `BAUD_DIV`, 5208: clocks per bit (50 MHz / 9600 baud); must be ≥ 8.
- `CODE_LEN`, 2: bytes in the GO sequence, 1..8.
- `GO_CODE`, 16'h4731 ("G1"): CODE_LEN*8 bits; the most significant byte is sent first.
- `STOP_CODE`, 8'h53 ("S"): single-byte stop command.
- `SEQ_TIMEOUT`, 2_500_000: max clocks between bytes of a GO sequence.
- `MAX_FAIL`, 3: consecutive failed sequences that cause lockout; ≥ 1.
- `LOCK_CYCLES`, 50_000_000: lockout duration in clocks.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `RX`  in  1  async serial input; idles high.
- `rider_off`  in  1  1 = no rider on platform (synchronous to `clk`).
- `pwr_up`  out  1  power enable to the balance controller.
- `locked`  out  1  high while in lockout.
- `frm_err`  out  1  one-cycle pulse when a byte has a bad stop bit.

## Operation
- **Receiver**
  - `RX` passes through a 2-flop synchroniser; both flops reset to 1.
  - In idle, a falling edge starts a baud counter. At BAUD_DIV/2 the start bit is re-sampled. If it is high, this is a glitch: return to idle with no output.
  - Then 8 data bits are sampled LSB first, one every BAUD_DIV clocks, followed by the stop bit.
  - Stop = 1: internal `byte_vld` pulses for 1 cycle with `byte`.
  - Stop = 0: `frm_err` pulses and the byte is discarded.
  - The receiver returns to idle in the cycle after the stop sample.
- **Auth FSM states:** OFF, COLLECT, ON, STOP_PEND, LOCKED.
  - Index `idx` has width $clog2(CODE_LEN+1). Fail counter `fails` has width $clog2(MAX_FAIL+1). Timers saturate, never wrap.
  - OFF: a byte equal to GO byte 0 goes to ON if CODE_LEN==1; otherwise it goes to COLLECT with idx=1 and the timer cleared. All other bytes, including STOP_CODE, are ignored with no fail counted.
  - COLLECT: a byte equal to GO byte idx increments idx. On the last byte: go to ON and clear `fails`.
  - COLLECT, mismatch: `fails`+1 and go to OFF. The mismatching byte is not re-evaluated as a new first byte.
  - COLLECT, timeout: if the inter-byte timer reaches SEQ_TIMEOUT with no byte, `fails`+1 and go to OFF.
  - Whenever the incremented `fails` equals MAX_FAIL, go to LOCKED instead of OFF.
  - ON: STOP_CODE with rider_off=1 goes to OFF. STOP_CODE with rider_off=0 goes to STOP_PEND. All other bytes are ignored.
  - STOP_PEND: rider_off=1 goes to OFF. Otherwise a byte equal to GO byte 0 returns to ON (single-byte cancel). Other bytes, including repeated STOP_CODE, are ignored.
  - STOP_PEND, simultaneous events: if rider_off=1 and `byte_vld` occur in the same cycle, rider_off wins and the state goes to OFF.
  - LOCKED: all bytes are ignored and the lock timer counts. After LOCK_CYCLES clocks, go to OFF with `fails`=0.
- **Outputs**
  - `pwr_up` = state ∈ {ON, STOP_PEND}, a decode of the state register (glitch-free).
  - `locked` = state == LOCKED.
  - `frm_err` is a registered pulse.
- **Reset**
  - All outputs are 0 out of reset.
  - State = OFF; idx, fails and timers are 0; the receiver is idle.
  - A reset mid-byte, mid-sequence or mid-lock abandons everything. No partial state survives.

## Timing
- **Byte acceptance:** `byte_vld` asserts 1 cycle after the stop-bit sample, which is ~9.5 bit-times after the start-bit falling edge (+2 cycles for the synchroniser).
- **Power up:** `pwr_up` rises on the edge ending the `byte_vld` cycle of the final GO byte.
- **Power down:**
  - `pwr_up` falls on the edge ending the STOP_CODE `byte_vld` cycle (ON, rider off).
  - In STOP_PEND, `pwr_up` falls on the first edge with rider_off=1.
- **Timeout:** fires on the cycle the timer equals SEQ_TIMEOUT. A byte arriving in that same cycle is processed, and the timeout is ignored.
- **Lockout:** `locked` is high for exactly LOCK_CYCLES cycles.
- **Throughput:** back-to-back bytes (stop bit immediately followed by a start bit) must be received without loss.

## Test plan
Bench settings: BAUD_DIV=16, CODE_LEN=2, GO_CODE=16'h4731, SEQ_TIMEOUT=2000, MAX_FAIL=3, LOCK_CYCLES=5000, loopback from `UART_tx`.

1. **Power up:** after reset, pwr_up=0 and locked=0. Send 0x42 → pwr_up stays 0 and fails=0. Send 0x47, 0x31 → pwr_up=1 one cycle after the second `byte_vld`.
2. **Stop pending:** in ON with rider_off=0, send 0x53 → pwr_up=1 (STOP_PEND). Send 0x47 → ON. Send 0x53 → STOP_PEND. Set rider_off=1 → pwr_up=0 on the next edge. In ON with rider_off=1, send 0x53 → pwr_up=0 immediately.
3. **Lockout:** send (0x47, 0x32) ×3 → locked=1 after the third 0x32. Send 0x47, 0x31 during lock → pwr_up stays 0. After 5000 cycles locked=0. Send 0x47, 0x31 → pwr_up=1.
4. **Timeout:** send 0x47, then idle for 2000+ cycles → OFF with fails=1. Send 0x31 alone → pwr_up stays 0. A subsequent full 0x47, 0x31 powers up and fails=0.
5. **Framing error:** send 0x47 with stop bit forced 0 → one `frm_err` pulse and the state stays OFF. A 1/4-bit low glitch on RX → no byte and no `frm_err`.
6. **Reset mid-operation:** assert rst for 1 cycle mid-byte and again in COLLECT and LOCKED → all outputs 0, then normal GO sequence works.
